// File: rtl/scnn_pkg.sv
// Shared types for the sparse convolution engine: FSM states, data widths and the
// compressed weight-list entry produced by the scanner and consumed by every PE.
package scnn_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W  = 32;

  typedef enum logic [1:0] {
    IDLE,
    WSCAN,
    COMPUTE,
    DONE
  } state_t;

  typedef logic [DEF_DATA_W-1:0]   act_t;
  typedef logic [DEF_ACC_W-1:0]    acc_t;
  typedef logic [2*DEF_DATA_W-1:0] prod_t;
  typedef logic [7:0]              coord_t;

  typedef struct packed {
    coord_t i;
    coord_t j;
    act_t   val;
  } wl_entry_t;

endpackage

// File: rtl/scnn_pe.sv
// One Cartesian-product PE: walks its owned rows of the activation plane and, for each
// nonzero activation, emits one product per cycle against the compressed weight list.
module scnn_pe
  import scnn_pkg::*;
#(
  parameter int PE_ID   = 0,
  parameter int NUM_PE  = 4,
  parameter int IP_SIZE = 64,
  parameter int WT_SIZE = 25,
  parameter int IDX_W   = 6,
  parameter int NNZ_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             empty,
  input  logic             run,
  input  logic [7:0]       input_dim,
  input  logic [3:0]       weight_dim,
  input  act_t             acts [IP_SIZE],
  input  wl_entry_t        wlist [WT_SIZE],
  input  logic [NNZ_W-1:0] nnz_w,
  output logic             valid,
  output prod_t            prod,
  output logic [IDX_W-1:0] tgt,
  output logic             fin
);

  coord_t           row;
  coord_t           col;
  logic [NNZ_W-1:0] widx;
  logic [IDX_W-1:0] pos;
  act_t             act;
  wl_entry_t        w;
  int               tr;
  int               tc;
  logic             act_nz;
  logic             in_range;
  logic             last_w;

  always_comb begin
    pos      = IDX_W'(row) * IDX_W'(input_dim) + IDX_W'(col);
    act      = acts[pos];
    w        = wlist[widx];
    tr       = int'(row) - int'(w.i) + int'(weight_dim >> 1);
    tc       = int'(col) - int'(w.j) + int'(weight_dim >> 1);
    act_nz   = (act != '0);
    in_range = (tr >= 0) && (tr < int'(input_dim)) && (tc >= 0) && (tc < int'(input_dim));
    valid    = run && !fin && act_nz && in_range;
    prod     = prod_t'(act) * prod_t'(w.val);
    tgt      = IDX_W'(tr) * IDX_W'(input_dim) + IDX_W'(tc);
    last_w   = (widx == nnz_w - NNZ_W'(1));
  end

  // A zero activation or the last weight of a nonzero one moves to the next owned position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row  <= coord_t'(PE_ID);
      col  <= '0;
      widx <= '0;
      fin  <= 1'b1;
    end else if (load) begin
      row  <= coord_t'(PE_ID);
      col  <= '0;
      widx <= '0;
      fin  <= empty || (PE_ID >= int'(input_dim));
    end else if (run && !fin) begin
      if (act_nz && !last_w) begin
        widx <= widx + NNZ_W'(1);
      end else begin
        widx <= '0;
        if (col == input_dim - 8'd1) begin
          col <= '0;
          if (int'(row) + NUM_PE >= int'(input_dim)) fin <= 1'b1;
          else                                       row <= row + coord_t'(NUM_PE);
        end else begin
          col <= col + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/scnn_conv_engine.sv
// Sparse "same" convolution engine: weight scanner builds a nonzero-weight list, NUM_PE PEs
// stream products, and a collision-summing accumulator plane collects them.
module scnn_conv_engine
  import scnn_pkg::*;
#(
  parameter int PARAM_IP_DIM  = 8,
  parameter int PARAM_WT_DIM  = 5,
  parameter int PARAM_IP_SIZE = PARAM_IP_DIM * PARAM_IP_DIM,
  parameter int PARAM_WT_SIZE = PARAM_WT_DIM * PARAM_WT_DIM,
  parameter int NUM_PE        = 4,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int ACC_W         = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] input_acts [PARAM_IP_SIZE],
  input  logic [7:0]        input_dim,
  input  logic [DATA_W-1:0] weights [PARAM_WT_SIZE],
  input  logic [3:0]        weight_dim,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  outputs [PARAM_IP_SIZE]
);

  localparam int IDX_W  = $clog2(PARAM_IP_SIZE);
  localparam int WIDX_W = $clog2(PARAM_WT_SIZE);
  localparam int NNZ_W  = $clog2(PARAM_WT_SIZE + 1);

  state_t            state_q;
  state_t            state_d;
  act_t              act_q [PARAM_IP_SIZE];
  act_t              wt_q [PARAM_WT_SIZE];
  coord_t            input_dim_q;
  logic [3:0]        weight_dim_q;
  wl_entry_t         wlist [PARAM_WT_SIZE];
  logic [NNZ_W-1:0]  nnz_w;
  logic [WIDX_W-1:0] sidx;
  coord_t            si;
  coord_t            sj;
  logic [7:0]        wd_sq;
  logic              accept;
  logic              scan_last;
  logic              pe_load;
  logic              pe_empty;
  logic              pe_run;
  logic              all_fin;
  logic [NUM_PE-1:0] pe_valid;
  logic [NUM_PE-1:0] pe_fin;
  prod_t             pe_prod [NUM_PE];
  logic [IDX_W-1:0]  pe_tgt [NUM_PE];
  acc_t              acc_add [PARAM_IP_SIZE];

  assign accept    = (state_q == IDLE) && start;
  assign wd_sq     = 8'(weight_dim_q) * 8'(weight_dim_q);
  assign scan_last = (8'(sidx) == wd_sq - 8'd1);
  assign pe_load   = (state_q == WSCAN) && scan_last;
  assign pe_empty  = (nnz_w == '0) && (wt_q[sidx] == '0);
  assign pe_run    = (state_q == COMPUTE);
  assign all_fin   = &pe_fin;

  // NOTE: every clocked register uses <= so all flops sample the values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: defaults come first so no branch of the case can leave a signal unassigned (no latch).
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = WSCAN;
      WSCAN: begin
        busy = 1'b1;
        if (scan_last) state_d = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (all_fin) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the plane copies carry no reset; an accepted start always rewrites them before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < PARAM_IP_SIZE; k++) act_q[k] <= input_acts[k];
      for (int k = 0; k < PARAM_WT_SIZE; k++) wt_q[k]  <= weights[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      input_dim_q  <= '0;
      weight_dim_q <= '0;
      nnz_w        <= '0;
      sidx         <= '0;
      si           <= '0;
      sj           <= '0;
      for (int k = 0; k < PARAM_WT_SIZE; k++) wlist[k] <= '0;
    end else if (accept) begin
      input_dim_q  <= input_dim;
      weight_dim_q <= weight_dim;
      nnz_w        <= '0;
      sidx         <= '0;
      si           <= '0;
      sj           <= '0;
    end else if (state_q == WSCAN) begin
      if (wt_q[sidx] != '0) begin
        wlist[nnz_w] <= '{i: si, j: sj, val: wt_q[sidx]};
        nnz_w        <= nnz_w + NNZ_W'(1);
      end
      sidx <= sidx + WIDX_W'(1);
      if (sj == coord_t'(weight_dim_q) - 8'd1) begin
        sj <= '0;
        si <= si + 8'd1;
      end else begin
        sj <= sj + 8'd1;
      end
    end
  end

  for (genvar p = 0; p < NUM_PE; p++) begin : g_pe
    scnn_pe #(
      .PE_ID  (p),
      .NUM_PE (NUM_PE),
      .IP_SIZE(PARAM_IP_SIZE),
      .WT_SIZE(PARAM_WT_SIZE),
      .IDX_W  (IDX_W),
      .NNZ_W  (NNZ_W)
    ) u_pe (
      .clk       (clk),
      .rst       (rst),
      .load      (pe_load),
      .empty     (pe_empty),
      .run       (pe_run),
      .input_dim (input_dim_q),
      .weight_dim(weight_dim_q),
      .acts      (act_q),
      .wlist     (wlist),
      .nnz_w     (nnz_w),
      .valid     (pe_valid[p]),
      .prod      (pe_prod[p]),
      .tgt       (pe_tgt[p]),
      .fin       (pe_fin[p])
    );
  end

  // Products from different PEs landing on the same entry in one cycle are all summed.
  always_comb begin
    for (int k = 0; k < PARAM_IP_SIZE; k++) begin
      acc_add[k] = '0;
      for (int p = 0; p < NUM_PE; p++) begin
        if (pe_valid[p] && (pe_tgt[p] == IDX_W'(k))) acc_add[k] = acc_add[k] + acc_t'(pe_prod[p]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < PARAM_IP_SIZE; k++) outputs[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < PARAM_IP_SIZE; k++) outputs[k] <= '0;
    end else if (state_q == COMPUTE) begin
      for (int k = 0; k < PARAM_IP_SIZE; k++) outputs[k] <= outputs[k] + acc_add[k];
    end
  end

endmodule
